// File: rtl/desempaquetador_operandos.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : desempaquetador_operandos                                     |
// | Purpose  : Input stage of the FP multiplier. Buffers packed 16-bit       |
// |            operand pairs in a small FIFO and stores, per entry, the      |
// |            unpacked mantissa fractions, result sign, biased result       |
// |            exponent (before normalisation) and zero/overflow/underflow  |
// |            flags. Operand: [15] sign, [14:8] exponent (bias 63),         |
// |            [7:0] fraction.                                               |
// | Ports    : i_clock, i_reset (sync, active high)                          |
// |            i_valid/o_ready, i_operando_1/2  : upstream handshake + data  |
// |            o_valid/i_ready                  : downstream handshake       |
// |            o_mantiza_1/2, o_signo, o_exponente, o_cero, o_overflow,      |
// |            o_underflow : head entry fields (0 while o_valid = 0)         |
// |            o_ocupacion : number of stored entries                        |
// | Config   : DESEMPAQUETADOR_FLUSH_CERO_EN forces stored mantissas to 0    |
// |            for entries flagged cero.                                     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module desempaquetador_operandos #(
  parameter int PROFUNDIDAD = 2
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic                         i_valid,
  input  logic [15:0]                  i_operando_1,
  input  logic [15:0]                  i_operando_2,
  output logic                         o_ready,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [7:0]                   o_mantiza_1,
  output logic [7:0]                   o_mantiza_2,
  output logic                         o_signo,
  output logic [6:0]                   o_exponente,
  output logic                         o_cero,
  output logic                         o_overflow,
  output logic                         o_underflow,
  output logic [$clog2(PROFUNDIDAD):0] o_ocupacion
);

  localparam int unsigned AW = $clog2(PROFUNDIDAD);
  // Entry layout: {mant1[7:0], mant2[7:0], signo, exponente[6:0], cero, ovf, unf}
  localparam int unsigned EW = 27;
  localparam logic [AW:0] c_PROF_CNT = (AW+1)'(PROFUNDIDAD);

  // ---------------------------------------------------------------- unpack
  logic [6:0]    w_e1;
  logic [6:0]    w_e2;
  logic [7:0]    w_suma;
  logic          w_cero;
  logic          w_ovf;
  logic          w_unf;
  logic [6:0]    w_exp;
  logic [7:0]    w_mant_1;
  logic [7:0]    w_mant_2;
  logic [EW-1:0] w_entry;

  assign w_e1   = i_operando_1[14:8];
  assign w_e2   = i_operando_2[14:8];
  assign w_suma = {1'b0, w_e1} + {1'b0, w_e2};
  assign w_cero = (w_e1 == 7'd0) || (w_e2 == 7'd0);
  // suma = biased_result + 63, so >= 190 means biased >= 127 (reserved)
  assign w_ovf  = !w_cero && (w_suma >= 8'd190);
  assign w_unf  = !w_cero && (w_suma <= 8'd63);

  // In the normal range suma - 63 lies in 1..126, so 7-bit arithmetic suffices
  always_comb begin
    w_exp = w_suma[6:0] - 7'd63;
    if (w_ovf) begin
      w_exp = 7'd127;
    end else if (w_unf || w_cero) begin
      w_exp = 7'd0;
    end
  end

`ifdef DESEMPAQUETADOR_FLUSH_CERO_EN
  // Zero operands present 0x00 x 0x00 so the multiplier needs no special case
  assign w_mant_1 = w_cero ? 8'h00 : i_operando_1[7:0];
  assign w_mant_2 = w_cero ? 8'h00 : i_operando_2[7:0];
`else
  assign w_mant_1 = i_operando_1[7:0];
  assign w_mant_2 = i_operando_2[7:0];
`endif

  assign w_entry = {w_mant_1, w_mant_2, i_operando_1[15] ^ i_operando_2[15],
                    w_exp, w_cero, w_ovf, w_unf};

  // ---------------------------------------------------------------- FIFO
  logic [EW-1:0] mem_q [PROFUNDIDAD];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          w_push;
  logic          w_pop;
  logic          w_valid;
  logic [EW-1:0] w_head;

  assign w_valid = (cnt_q != '0);
  // Ready depends only on the registered count: a full FIFO refuses a push
  // even when a pop happens in the same cycle.
  assign o_ready = (cnt_q < c_PROF_CNT);
  assign w_push  = i_valid && o_ready && !i_reset;
  assign w_pop   = w_valid && i_ready && !i_reset;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (w_push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (w_push && !w_pop) begin
      cnt_d = cnt_q + (AW+1)'(1);
    end else if (w_pop && !w_push) begin
      cnt_d = cnt_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only observed while counted as valid
  always_ff @(posedge i_clock) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= w_entry;
    end
  end

  // ---------------------------------------------------------------- outputs
  assign w_head      = w_valid ? mem_q[rd_ptr_q] : '0;
  assign o_valid     = w_valid;
  assign o_ocupacion = cnt_q;
  assign {o_mantiza_1, o_mantiza_2, o_signo, o_exponente,
          o_cero, o_overflow, o_underflow} = w_head;

endmodule
`default_nettype wire

// File: tb/tb_desempaquetador_operandos.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_desempaquetador_operandos                                  |
// | Purpose  : Scoreboard bench for desempaquetador_operandos. Accepted      |
// |            pairs are turned into expected entries by an arithmetic       |
// |            reference model and queued; a monitor compares the DUT head   |
// |            against the queue every cycle.                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_desempaquetador_operandos;

  localparam int PROF = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iv  = 1'b0;
  logic        ir  = 1'b0;
  logic [15:0] op1 = '0;
  logic [15:0] op2 = '0;
  logic        o_ready, o_valid, o_signo, o_cero, o_overflow, o_underflow;
  logic [7:0]  o_mantiza_1, o_mantiza_2;
  logic [6:0]  o_exponente;
  logic [$clog2(PROF):0] o_ocupacion;

  desempaquetador_operandos #(.PROFUNDIDAD(PROF)) dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_valid      (iv),
    .i_operando_1 (op1),
    .i_operando_2 (op2),
    .o_ready      (o_ready),
    .o_valid      (o_valid),
    .i_ready      (ir),
    .o_mantiza_1  (o_mantiza_1),
    .o_mantiza_2  (o_mantiza_2),
    .o_signo      (o_signo),
    .o_exponente  (o_exponente),
    .o_cero       (o_cero),
    .o_overflow   (o_overflow),
    .o_underflow  (o_underflow),
    .o_ocupacion  (o_ocupacion)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] m1;
    logic [7:0] m2;
    logic       s;
    logic [6:0] e;
    logic       z;
    logic       o;
    logic       u;
  } ent_t;

  ent_t sb[$];
  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  // Reference model: real exponent arithmetic with signed integers
  function automatic ent_t model(input logic [15:0] a, input logic [15:0] b);
    ent_t r;
    int ea, eb, biased;
    ea = int'(a[14:8]);
    eb = int'(b[14:8]);
    biased = (ea - 63) + (eb - 63) + 63;
    r = '0;
    r.s  = a[15] ^ b[15];
    r.m1 = a[7:0];
    r.m2 = b[7:0];
    if (ea == 0 || eb == 0) begin
      r.z = 1'b1;
`ifdef DESEMPAQUETADOR_FLUSH_CERO_EN
      r.m1 = 8'h00;
      r.m2 = 8'h00;
`endif
    end else if (biased >= 127) begin
      r.o = 1'b1;
      r.e = 7'd127;
    end else if (biased <= 0) begin
      r.u = 1'b1;
    end else begin
      r.e = 7'(biased);
    end
    return r;
  endfunction

  // Scoreboard update, driven by the model's own occupancy
  always @(posedge clk) begin
    int n;
    n = sb.size();
    if (rst) begin
      sb.delete();
    end else begin
      if (ir && n > 0) void'(sb.pop_front());
      if (iv && n < PROF) sb.push_back(model(op1, op2));
    end
  end

  // Monitor: compare head and status against the scoreboard away from the edge
  always @(negedge clk) begin
    ent_t h;
    if (mon_en) begin
      h = (sb.size() > 0) ? sb[0] : '0;
      chk("ocupacion", 32'(o_ocupacion), 32'(sb.size()));
      chk("valid", 32'(o_valid), 32'(sb.size() > 0));
      chk("ready", 32'(o_ready), 32'(sb.size() < PROF));
      chk("head", {5'd0, o_mantiza_1, o_mantiza_2, o_signo, o_exponente,
                   o_cero, o_overflow, o_underflow}, 32'(h));
    end
  end

  // Present a pair from a negedge; returns on the negedge after acceptance
  task automatic send(input logic [15:0] a, input logic [15:0] b);
    int t;
    t = 0;
    iv = 1'b1; op1 = a; op2 = b;
    while (!o_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("send_timeout", 32'd1, 32'd0);
    @(negedge clk);
    iv = 1'b0;
  endtask

  task automatic send_chk(input logic [15:0] a, input logic [15:0] b,
                          input logic [7:0] m1, input logic [7:0] m2, input logic s,
                          input logic [6:0] e, input logic z, input logic o, input logic u);
    send(a, b);
    chk("d_valid", 32'(o_valid), 32'd1);
    chk("d_fields", {o_mantiza_1, o_mantiza_2, o_signo, o_exponente, o_cero, o_overflow, o_underflow},
                    {m1, m2, s, e, z, o, u});
  endtask

  function automatic logic [15:0] rnd_op();
    logic [6:0] e;
    case ($urandom_range(0, 3))
      0: e = 7'($urandom_range(0, 2));
      1: e = 7'($urandom_range(120, 127));
      default: e = 7'($urandom_range(0, 127));
    endcase
    return {1'($urandom()), e, 8'($urandom())};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit done3;
    bit rdone;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    chk("rst_ocup", 32'(o_ocupacion), 32'd0);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_ready", 32'(o_ready), 32'd1);

    // Directed vectors
    ir = 1'b1;
    send_chk(16'h3F80, 16'h4000, 8'h80, 8'h00, 1'b0, 7'd64, 1'b0, 1'b0, 1'b0);
    chk("d_ocup1", 32'(o_ocupacion), 32'd1);
    send_chk(16'hBF00, 16'h3F00, 8'h00, 8'h00, 1'b1, 7'd63, 1'b0, 1'b0, 1'b0);
    send_chk(16'h7E00, 16'h7E00, 8'h00, 8'h00, 1'b0, 7'd127, 1'b0, 1'b1, 1'b0);
    send_chk(16'h0100, 16'h0100, 8'h00, 8'h00, 1'b0, 7'd0, 1'b0, 1'b0, 1'b1);
`ifdef DESEMPAQUETADOR_FLUSH_CERO_EN
    send_chk(16'h0055, 16'h3F80, 8'h00, 8'h00, 1'b0, 7'd0, 1'b1, 1'b0, 1'b0);
`else
    send_chk(16'h0055, 16'h3F80, 8'h55, 8'h80, 1'b0, 7'd0, 1'b1, 1'b0, 1'b0);
`endif
    @(negedge clk);

    // Backpressure: third pair must wait upstream, head stays the first pair
    ir = 1'b0;
    send(16'h4011, 16'h4022);
    send(16'h4133, 16'h4244);
    done3 = 1'b0;
    fork
      begin send(16'hC355, 16'h3E66); done3 = 1'b1; end
    join_none
    repeat (3) @(negedge clk);
    chk("bp_ready", 32'(o_ready), 32'd0);
    chk("bp_head", {o_mantiza_1, o_mantiza_2}, 32'h1122);
    ir = 1'b1;
    for (int i = 0; i < 20 && !done3; i++) @(negedge clk);
    chk("bp_done", 32'(done3), 32'd1);
    repeat (3) @(negedge clk);

    // Streaming: one pair per cycle, occupancy stays at 1
    for (int i = 0; i < 10; i++) begin
      send(rnd_op(), rnd_op());
      chk("stream_ocup", 32'(o_ocupacion), 32'd1);
    end
    @(negedge clk);

    // Random traffic with random downstream stalls
    rdone = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          send(rnd_op(), rnd_op());
          repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        rdone = 1'b1;
      end
      begin
        while (!rdone) begin
          ir = ($urandom_range(0, 3) != 0);
          @(negedge clk);
        end
      end
    join
    ir = 1'b1;
    repeat (4) @(negedge clk);

    // Reset while full, with a push offered in the reset cycle
    ir = 1'b0;
    send(16'h4001, 16'h4002);
    send(16'h4003, 16'h4004);
    chk("pre_rst_ocup", 32'(o_ocupacion), 32'd2);
    ir = 1'b1;
    iv = 1'b1; op1 = 16'h4005; op2 = 16'h4006;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    iv = 1'b0;
    chk("mid_rst_ocup", 32'(o_ocupacion), 32'd0);
    chk("mid_rst_valid", 32'(o_valid), 32'd0);
    chk("mid_rst_data", {o_mantiza_1, o_mantiza_2, o_exponente, o_signo}, 32'd0);
    send_chk(16'h3F80, 16'h4000, 8'h80, 8'h00, 1'b0, 7'd64, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/desempaquetador_operandos.md
# desempaquetador_operandos

Input stage of the floating-point multiplier datapath, directly upstream of `multiplicador_mantiza`. It accepts pairs of packed 16-bit floating-point operands over a valid/ready handshake and buffers them in a small FIFO. Each pair is unpacked into the two 8-bit mantissa fields (hidden 1 not included) that feed the mantissa multiplier, plus the result sign, the biased result exponent and zero/overflow/underflow flags. Operand format: bit [15] sign, [14:8] exponent (bias 63, value 0 = zero, no denormals), [7:0] mantissa fraction.

## Interface
- `PROFUNDIDAD`, default 2: FIFO depth in operand pairs; power of two, ≥ 2.
- `i_clock` input 1: single clock; everything updates on the rising edge.
- `i_reset` input 1: synchronous, active-high reset.
- `i_valid` input 1: upstream operand pair valid.
- `i_operando_1` input 16: packed operand 1.
- `i_operando_2` input 16: packed operand 2.
- `o_ready` output 1: stage can accept a pair this cycle.
- `o_valid` output 1: head entry valid toward the multiplier.
- `i_ready` input 1: downstream accepts the head entry.
- `o_mantiza_1` output 8: mantissa fraction of operand 1.
- `o_mantiza_2` output 8: mantissa fraction of operand 2.
- `o_signo` output 1: sign1 XOR sign2.
- `o_exponente` output 7: biased result exponent before mantissa normalisation.
- `o_cero` output 1: either operand has exponent 0.
- `o_overflow` output 1: exponent out of range high.
- `o_underflow` output 1: exponent out of range low.
- `o_ocupacion` output $clog2(PROFUNDIDAD)+1: number of stored entries.

## Operation
- A push occurs when `i_valid && o_ready`. A pop occurs when `o_valid && i_ready`.
- `o_ready = (o_ocupacion < PROFUNDIDAD)`. It depends only on the registered count. When the FIFO is full and a pop happens in the same cycle, `o_ready` is still 0, so no push occurs.
- Fields are computed at write time and stored per entry.
  - `e1` = op1[14:8], `e2` = op2[14:8], `suma` = e1 + e2, 8 bits wide, no wrap.
  - cero = (e1 == 0) || (e2 == 0).
  - overflow = !cero && (suma ≥ 190), i.e. biased ≥ 127; exponent 127 is reserved.
  - underflow = !cero && (suma ≤ 63), i.e. biased ≤ 0.
  - Exponent: 127 if overflow; 0 if underflow or cero; otherwise suma − 63.
  - Sign: op1[15] ^ op2[15], regardless of cero.
- Flag priority: cero over overflow/underflow. At most one flag is set per entry.
- Push and pop in the same cycle (FIFO not full, not empty): the count is unchanged and both pointers advance.
- Pointers wrap modulo `PROFUNDIDAD`. The count saturates at neither end; the handshake rules prevent overflow and underflow of the FIFO.
- The normalisation +1 on the exponent is applied downstream, after the mantissa product. This block does not apply it.

## Timing
- Latency is 1 cycle. A pair pushed at edge N appears on the outputs with `o_valid = 1` after edge N. There is no same-cycle pass-through.
- Throughput is 1 pair per cycle when `i_ready` is held at 1.
- All outputs are registered or derived from registered state. There is no combinational path from `i_valid`/`i_operando_*` or `i_ready` to any output.
- While `o_valid = 0`, all data outputs (`o_mantiza_*`, `o_signo`, `o_exponente`, flags) read 0.
- The head entry is held stable while `o_valid && !i_ready`.
- Reset values: `o_valid` 0, `o_ready` 1 (after the reset cycle), `o_ocupacion` 0, all data outputs 0. Pointers are set to 0.
- Reset asserted mid-operation discards all stored entries at that edge. A push or pop in the reset cycle is ignored.

## Configuration
- `DESEMPAQUETADOR_FLUSH_CERO_EN` defined: when cero = 1, stored `o_mantiza_1` and `o_mantiza_2` are forced to 0x00. The multiplier then sees 0×0, and the zero result flows through without special casing.
- Not defined: mantissa fields pass through unchanged for zero operands; only `o_cero` marks them.
- All other behaviour is identical in both builds.

## Test plan
- Reset, then push 0x3F80 × 0x4000 (1.5 × 2.0) → next cycle `o_valid` = 1, mantissas 0x80/0x00, signo 0, exponente 64, all flags 0, ocupacion 1.
- Push 0xBF00 × 0x3F00 → signo 1, exponente 63. Push 0x7E00 × 0x7E00 → overflow 1, exponente 127. Push 0x0100 × 0x0100 → underflow 1, exponente 0.
- Push 0x0055 × 0x3F80 → cero 1, exponente 0. With the macro: mantissas 0x00/0x00. Without the macro: mantissas 0x55/0x80.
- `i_ready` = 0, push 3 pairs with `PROFUNDIDAD` = 2 → `o_ready` drops after 2 pushes, the third pair is held upstream, and outputs remain equal to the first pair. Raise `i_ready` → pairs emerge in order with no loss and no duplication.
- `i_valid` = `i_ready` = 1 continuously for 10 pairs → one output per cycle after 1 cycle latency, and ocupacion stays at 1.
- Fill the FIFO, then assert `i_reset` for 1 cycle with `i_valid` = 1 → ocupacion 0, `o_valid` 0, outputs 0, nothing written.
